// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit: funct3 op codes
// and sequencer states, plus the two's-complement helper used in PREP and FIX.
package mdu_seq_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/mdu_seq_adder.sv
// The single shared 32-bit adder: add_or_sub=1 computes a - b as a + ~b + 1,
// so cf=1 on subtract means "no borrow".
module mdu_seq_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add_or_sub,
    output logic [31:0] sum,
    output logic        cf
);

    always_comb begin
        {cf, sum} = {1'b0, a} + {1'b0, b ^ {32{add_or_sub}}} + {32'd0, add_or_sub};
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M MUL/DIV unit: shift-add multiply and restoring divide over
// XLEN cycles through one shared adder, with valid/ready handshakes and kill.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [5:0] LAST = 6'(XLEN - 1);

    state_e          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;   // rs1 -> |a| -> multiplier/product lo or quotient
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] opnd_b_q, opnd_b_d;   // rs2 -> |b| (multiplicand or divisor)
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] add_a, add_b, add_sum;
    logic            add_sub, add_cf;

    logic            signed_a, signed_b, is_div, div_zero, div_ovf, shortcut;
    logic            sa_now, sb_now, success;
    logic [XLEN-1:0] rem_shift, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod_fix;

    mdu_seq_adder u_adder (
        .a          (add_a),
        .b          (add_b),
        .add_or_sub (add_sub),
        .sum        (add_sum),
        .cf         (add_cf)
    );

    // Operand classification is taken from the latched op, valid from PREP on.
    always_comb begin
        signed_a = (op_q == MDU_MULH) || (op_q == MDU_MULHSU) ||
                   (op_q == MDU_DIV)  || (op_q == MDU_REM);
        signed_b = (op_q == MDU_MULH) || (op_q == MDU_DIV) || (op_q == MDU_REM);
        is_div   = op_q[2];
        div_zero = is_div && (opnd_b_q == '0);
        div_ovf  = is_div && !op_q[0] && (acc_lo_q == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (opnd_b_q == '1);
        shortcut = div_zero || div_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_PREP;
            S_PREP:  state_d = shortcut ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = result_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        rem_d     = rem_q;
        opnd_b_d  = opnd_b_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        op_d      = op_q;
        result_d  = result_q;
        add_a     = acc_hi_q;
        add_b     = '0;
        add_sub   = 1'b0;
        sa_now    = signed_a && acc_lo_q[XLEN-1];
        sb_now    = signed_b && opnd_b_q[XLEN-1];
        rem_shift = {rem_q[XLEN-2:0], acc_lo_q[XLEN-1]};
        success   = 1'b0;
        prod_fix  = {acc_hi_q, acc_lo_q};
        quo_fix   = acc_lo_q;
        rem_fix   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d     = op;
                    acc_lo_d = rs1;
                    opnd_b_d = rs2;
                end
            end
            S_PREP: begin
                sign_a_d = sa_now;
                sign_b_d = sb_now;
                acc_lo_d = sa_now ? neg32(acc_lo_q) : acc_lo_q;
                opnd_b_d = sb_now ? neg32(opnd_b_q) : opnd_b_q;
                acc_hi_d = '0;
                rem_d    = '0;
                cnt_d    = '0;
                if (div_zero)     result_d = op_q[1] ? acc_lo_q : '1;
                else if (div_ovf) result_d = op_q[1] ? '0 : acc_lo_q;
            end
            S_CALC: begin
                cnt_d = (cnt_q == LAST) ? 6'd0 : cnt_q + 6'd1;
                if (!is_div) begin
                    add_a    = acc_hi_q;
                    add_b    = acc_lo_q[0] ? opnd_b_q : '0;
                    acc_hi_d = {add_cf, add_sum[XLEN-1:1]};
                    acc_lo_d = {add_sum[0], acc_lo_q[XLEN-1:1]};
                end else begin
                    // The bit shifted out of rem makes the trial succeed regardless of CF.
                    add_a    = rem_shift;
                    add_b    = opnd_b_q;
                    add_sub  = 1'b1;
                    success  = rem_q[XLEN-1] | add_cf;
                    rem_d    = success ? add_sum : rem_shift;
                    acc_lo_d = {acc_lo_q[XLEN-2:0], success};
                end
            end
            S_FIX: begin
                if (sign_a_q ^ sign_b_q) begin
                    prod_fix = ~{acc_hi_q, acc_lo_q} + 64'd1;
                    quo_fix  = neg32(acc_lo_q);
                end
                if (sign_a_q) rem_fix = neg32(rem_q);
                case (op_q)
                    MDU_MUL:                          result_d = prod_fix[XLEN-1:0];
                    MDU_MULH, MDU_MULHSU, MDU_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                    MDU_DIV, MDU_DIVU:               result_d = quo_fix;
                    default:                          result_d = rem_fix;
                endcase
            end
            default: ;
        endcase
        if (kill) result_d = result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            rem_q    <= '0;
            opnd_b_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            rem_q    <= rem_d;
            opnd_b_q <= opnd_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

endmodule
